// File: rtl/zprize_mul_feeder_pkg.sv
// Shared types and helpers for the multiplier feeder: flush FSM states,
// result entry layout and pointer sizing.
package zprize_mul_feeder_pkg;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } feeder_state_e;

  localparam int DEF_W0 = 384;
  localparam int DEF_W1 = 384;
  localparam int DEF_M  = 32;

  // Result entry for the default operand/tag widths; the top rebuilds the
  // same {product, tag} layout from its own parameters.
  typedef struct packed {
    logic [DEF_W0+DEF_W1-1:0] product;
    logic [DEF_M-1:0]         tag;
  } mul_entry_t;

  // One extra bit over the address so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zprize_sync_fifo.sv
// Single-clock show-ahead FIFO holding multiplier results until the
// downstream consumer is ready.
module zprize_sync_fifo
  import zprize_mul_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst) !(wr_en && full))
    else $error("zprize_sync_fifo: write while full");

endmodule

// File: rtl/zprize_mul_feeder.sv
// Credit-based issue/collect shell around a fixed-latency, non-stallable
// multiplier: operands pass straight through, products land in a local FIFO.
module zprize_mul_feeder
  import zprize_mul_feeder_pkg::*;
#(
  parameter int W0         = 384,
  parameter int W1         = 384,
  parameter int M          = 32,
  parameter int LAT        = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W0-1:0]   s_in0,
  input  logic [W1-1:0]   s_in1,
  input  logic [M-1:0]    s_meta,
  output logic [W0-1:0]   mul_in0,
  output logic [W1-1:0]   mul_in1,
  output logic [M:0]      mul_m_i,
  input  logic [W0+W1-1:0] mul_out0,
  input  logic [M:0]      mul_m_o,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W0+W1-1:0] m_out,
  output logic [M-1:0]    m_meta
);

  localparam int PW = W0 + W1;
  localparam int CW = ptr_w(FIFO_DEPTH);
  localparam int FW = $clog2(LAT + 1);

  typedef struct packed {
    logic [PW-1:0] product;
    logic [M-1:0]  tag;
  } entry_t;

  if (LAT < 1) begin : g_bad_lat
    $error("zprize_mul_feeder: LAT must be at least 1");
  end
  if (FIFO_DEPTH < LAT + 1) begin : g_bad_depth
    $error("zprize_mul_feeder: FIFO_DEPTH must be at least LAT+1");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_pow2
    $error("zprize_mul_feeder: FIFO_DEPTH must be a power of 2");
  end

  feeder_state_e  state_q;
  feeder_state_e  state_d;
  logic [FW-1:0]  flush_cnt_q;
  logic [FW-1:0]  flush_cnt_d;
  logic [CW-1:0]  credit_q;
  logic [CW-1:0]  credit_d;
  logic           flushing;
  logic           accept;
  logic           pop;
  logic           wr_en;
  logic           fifo_full;
  logic           fifo_empty;
  entry_t         wr_entry;
  entry_t         rd_entry;

  assign flushing = (state_q == FLUSH);
  assign s_ready  = (credit_q != '0) & ~flushing;
  assign accept   = s_valid & s_ready;
  assign pop      = m_valid & m_ready;

  // ---- issue: operands go straight to the multiplier, valid rides as tag MSB
  assign mul_in0 = s_in0;
  assign mul_in1 = s_in1;
  assign mul_m_i = {accept, s_meta};

  // Flush runs long enough to drain whatever the un-reset pipeline held.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else                   flush_cnt_d = flush_cnt_q - FW'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = FLUSH;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (flushing)              credit_d = CW'(FIFO_DEPTH);
    else if (accept && !pop)   credit_d = credit_q - CW'(1);
    else if (pop && !accept)   credit_d = credit_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FLUSH;
      flush_cnt_q <= FW'(LAT);
      credit_q    <= CW'(FIFO_DEPTH);
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      credit_q    <= credit_d;
    end
  end

  // ---- collect: multiplier output -> result FIFO -> downstream stream
  assign wr_en    = mul_m_o[M] & ~flushing;
  assign wr_entry = {mul_out0, mul_m_o[M-1:0]};

  zprize_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (m_ready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_out   = rd_entry.product;
  assign m_meta  = rd_entry.tag;

endmodule

// File: doc/zprize_mul_feeder.md
# zprize_mul_feeder

Credit-based issue/collect shell for a fixed-latency, non-stallable pipelined multiplier in the MSM datapath. The upstream side is a valid/ready operand stream; the block drives the multiplier's operand and metadata inputs and collects its product and metadata outputs. Beat validity travels down the multiplier's metadata channel as its MSB. Products are captured in a local FIFO and returned on a valid/ready stream, so a downstream stall never loses a result.

## Interface
Parameters:
- W0, 384: operand 0 width.
- W1, 384: operand 1 width.
- M, 32: user metadata width. The multiplier is instantiated with metadata width M+1.
- LAT, 5: multiplier latency in cycles, from operands/metadata in to out0/m_o.
- FIFO_DEPTH, 8: result FIFO entries. Must be a power of 2 and ≥ LAT+2 for full rate; elaboration error if < LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accepted when s_valid & s_ready.
- s_in0  in  W0  operand 0.
- s_in1  in  W1  operand 1.
- s_meta  in  M  user tag.
- mul_in0  out  W0  to multiplier in0.
- mul_in1  out  W1  to multiplier in1.
- mul_m_i  out  M+1  to multiplier m_i; bit M = valid, bits M-1:0 = tag.
- mul_out0  in  W0+W1  from multiplier out0.
- mul_m_o  in  M+1  from multiplier m_o.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream ready.
- m_out  out  W0+W1  product.
- m_meta  out  M  tag returned with the product.

## Operation
- Issue path is combinational pass-through:
  - mul_in0 = s_in0, mul_in1 = s_in1, mul_m_i[M-1:0] = s_meta.
  - mul_m_i[M] = s_valid & s_ready.
  - When no beat is accepted, the valid bit is 0 and the data are don't-care.
- Credit counter `credit`, range 0..FIFO_DEPTH, reset to FIFO_DEPTH:
  - Decrements on accept.
  - Increments on pop (m_valid & m_ready).
  - Accept and pop in the same cycle leave it unchanged.
  - s_ready = (credit != 0) & ~flushing. It is a function of registers only and never depends on m_ready.
- Capture: when mul_m_o[M] = 1, write {mul_out0, mul_m_o[M-1:0]} into the FIFO. Writes with mul_m_o[M] = 0 are ignored.
  - The credit scheme guarantees no overflow. Simulation assertion: write while full is an error.
- FIFO behaviour:
  - m_valid = ~empty; m_out/m_meta show the head entry.
  - Write and read in the same cycle are both allowed at any occupancy except full-with-write, which is unreachable.
  - Pointers wrap modulo FIFO_DEPTH; occupancy uses an extra pointer bit.
- Ordering: results leave in strict accept order. No reordering, no drops.
- Flush state machine (the multiplier pipeline has no reset):
  - States: FLUSH, RUN. Reset enters FLUSH with a counter loaded to LAT.
  - FLUSH → RUN when the counter reaches 0.
  - While in FLUSH: s_ready = 0, FIFO writes are suppressed, credit is held at FIFO_DEPTH.
- Reset mid-operation discards every in-flight and buffered beat. Stale multiplier outputs that emerge during FLUSH are ignored.

## Timing
- Reset values: s_ready = 0, m_valid = 0, mul_m_i[M] = 0, credit = FIFO_DEPTH, FIFO empty, state = FLUSH.
  - m_out/m_meta are don't-care while m_valid = 0.
- After rst deasserts, s_ready rises LAT+1 cycles later at the earliest, provided s_valid is not needed.
- Latency: a beat accepted at edge t is written at edge t+LAT, and m_valid is high from after edge t+LAT.
- Credit returned by a pop at edge p is usable for an accept at edge p+1.
- Throughput: 1 beat/cycle sustained when m_ready = 1 and FIFO_DEPTH ≥ LAT+2.
  - With FIFO_DEPTH = LAT+1: at most LAT+1 beats every LAT+2 cycles.
- Downstream stall: at most FIFO_DEPTH beats are outstanding (in flight plus buffered), after which s_ready = 0.

## Structure
- Package zprize_mul_feeder_pkg:
  - typedef for the FIFO entry struct {product, tag}.
  - function clog2-based pointer width.
  - FSM state enum {FLUSH, RUN}.
- Sub-module zprize_sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Single clock, async active-low reset, show-ahead read, full/empty outputs.
- The top level holds the credit counter, the flush FSM and the issue wiring.
- The multiplier itself is instantiated by the parent, not inside this block.

## Test plan
- Reset flush: drive mul_m_o[M] = 1 with garbage for LAT cycles after reset → no FIFO write, m_valid stays 0, s_ready rises at cycle LAT+1.
- Streaming: 100 back-to-back beats with m_ready = 1 and a behavioural LAT=5 multiplier → 100 results in order, correct products and tags, s_ready never drops after flush.
- Backpressure: m_ready = 0, offer 20 beats → exactly 8 accepted, then s_ready = 0. Release m_ready → all 8 drained in order, accepts resume one cycle after the first pop.
- Simultaneous accept + pop at credit = 1 → credit stays 1, no overflow assertion, ordering preserved.
- Random valid/ready toggling (50% each), 10k beats → scoreboard matches; FIFO full-with-write assertion never fires.
- Reset asserted with 3 beats in flight and 4 buffered → m_valid = 0 immediately, no stale results after reset, the next accepted beat returns correctly.
